auc_sched: RTL and testbench
============================

Name: auc_sched

Overview:
- Parametrised successor to the single-mode arithmetic-unit controller wrapper.
- Accepts queued commands through a valid/ready handshake and dispatches each to one of NENG function engines (rand, inv, r, s, wmul, mmul, ...).
- Owns the shared RAM port and AU control mux, and grants them to exactly one engine at a time.
- Adds a per-command watchdog, result-zero checking per engine, and illegal-mode rejection.

Parameters:
- WIDTH, 256, datapath/word width
- ADDR, 5, RAM address width
- NENG, 6, number of engines (1..2^MWID)
- MWID, 3, command mode width
- QLOG, 2, log2 of command FIFO depth (depth 4)
- CMD_ADD, 11, RAM address that receives cmd_dat at dispatch
- TWID, 16, watchdog counter width; timeout after 2^TWID-1 RUN cycles
- ZCHK, 6'b001100, per-engine mask; result==0 reports ERROR

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  FIFO not full
- cmd_mode  in  MWID  engine index
- cmd_dat  in  WIDTH  operand written to CMD_ADD at dispatch
- auc_rslt  out  WIDTH  last captured result
- auc_status  out  2  0 IDLE, 1 CAL, 2 DONE, 3 ERROR
- auc_busy  out  1  FSM not IDLE or FIFO non-empty
- eng_start  out  NENG  one-hot start pulse
- eng_abort  out  NENG  one-hot abort pulse on timeout
- eng_vld  in  NENG  engine done pulses
- eng_radd  in  NENG*ADDR  engine read addresses, engine i at [i*ADDR +: ADDR]
- eng_wen  in  NENG  engine write enables
- eng_wadd  in  NENG*ADDR  engine write addresses
- eng_wdat  in  NENG*WIDTH  engine write data
- eng_auop  in  NENG*4  engine AU opcodes
- eng_austart  in  NENG  engine AU starts
- eng_carry  in  NENG  engine AU carry-in
- ram_radd  out  ADDR  RAM read address
- ram_wen  out  1  RAM write enable
- ram_wadd  out  ADDR  RAM write address
- ram_wdat  out  WIDTH  RAM write data
- au_opcode  out  4  AU opcode
- au_start  out  1  AU start, registered
- au_carry  out  1  AU carry-in
- au_vld  in  1  AU result valid
- eng_auvld  out  NENG  au_vld gated to the selected engine

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: all outputs 0, except cmd_rdy=1. FIFO is emptied, FSM goes to IDLE, watchdog is cleared.
- FIFO handshake:
  - Push when cmd_vld & cmd_rdy.
  - cmd_rdy=0 when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: occupancy unchanged.
  - Pointers wrap modulo 2^QLOG.
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE:
  - FIFO non-empty and mode<NENG: pop, latch sel=mode, go to LOAD.
  - FIFO non-empty and mode>=NENG: pop, auc_status=ERROR for 1 cycle, auc_rslt unchanged, stay in IDLE.
- LOAD (1 cycle):
  - ram_wen=1, ram_wadd=CMD_ADD, ram_wdat=cmd_dat.
  - eng_start[sel]=1.
  - Watchdog cleared. Go to RUN.
- RUN:
  - ram_*, au_opcode and au_carry are driven combinationally from engine sel.
  - au_start = eng_austart[sel] delayed 1 cycle.
  - eng_auvld = au_vld on bit sel only.
  - Watchdog increments each cycle.
  - eng_vld[sel]=1: capture auc_rslt=eng_wdat[sel] in the same edge, go to FIN with a DONE or ERROR verdict. Verdict is ERROR if ZCHK[sel] and captured value==0, else DONE.
  - Watchdog reaches all-ones before vld: eng_abort[sel]=1 for 1 cycle, verdict ERROR, auc_rslt unchanged, go to FIN.
  - eng_vld[sel] and timeout in the same cycle: vld wins.
  - eng_vld on a non-selected engine is ignored.
- FIN (1 cycle): auc_status = verdict, go to IDLE. The next dispatch from IDLE takes at least 1 more cycle.
- auc_status encoding: CAL in LOAD and RUN, verdict in FIN, IDLE otherwise.
- Outside LOAD/RUN: ram_wen=0, au_start=0, eng_auvld=0, ram_radd=0.
- Reset mid-RUN: no abort pulse, state is discarded, queued commands are lost.
- Latency: push into an empty FIFO in cycle t gives LOAD at t+2 (t+1 is IDLE seeing non-empty).

Test Plan:
- Reset, then push mode=4 with cmd_dat=0x5A → cmd_rdy=1 throughout. LOAD at t+2 with ram_wadd=11 and ram_wdat=0x5A. eng_start=6'b010000. eng_vld[4] with eng_wdat=0x1234 → auc_rslt=0x1234, status DONE for 1 cycle.
- Push mode=2, engine returns 0 → status ERROR (ZCHK bit 2). Repeat with mode=5 returning 0 → DONE.
- Push mode=7 (>=NENG) → no eng_start, ERROR pulse, auc_rslt unchanged.
- TWID=4, engine never responds → eng_abort[sel] pulse exactly 15 cycles after LOAD, status ERROR, next command dispatches.
- Push 5 back-to-back commands while engine 0 is stalled → cmd_rdy drops after the 4th. All 4 execute in order after vld. eng_vld[1] asserted while sel=0 is ignored.
- Assert rst during RUN → all outputs reset, auc_busy=0, no eng_abort.

Source files
------------

// File: rtl/auc_sched.sv
// Command scheduler: queues mode/operand commands, dispatches each to one function
// engine, and owns the shared RAM port and AU control mux while that engine runs.
module auc_sched #(
  parameter int              WIDTH   = 256,
  parameter int              ADDR    = 5,
  parameter int              NENG    = 6,
  parameter int              MWID    = 3,
  parameter int              QLOG    = 2,
  parameter int              CMD_ADD = 11,
  parameter int              TWID    = 16,
  parameter logic [NENG-1:0] ZCHK    = 6'b001100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [MWID-1:0]       cmd_mode,
  input  logic [WIDTH-1:0]      cmd_dat,
  output logic [WIDTH-1:0]      auc_rslt,
  output logic [1:0]            auc_status,
  output logic                  auc_busy,
  output logic [NENG-1:0]       eng_start,
  output logic [NENG-1:0]       eng_abort,
  input  logic [NENG-1:0]       eng_vld,
  input  logic [NENG*ADDR-1:0]  eng_radd,
  input  logic [NENG-1:0]       eng_wen,
  input  logic [NENG*ADDR-1:0]  eng_wadd,
  input  logic [NENG*WIDTH-1:0] eng_wdat,
  input  logic [NENG*4-1:0]     eng_auop,
  input  logic [NENG-1:0]       eng_austart,
  input  logic [NENG-1:0]       eng_carry,
  output logic [ADDR-1:0]       ram_radd,
  output logic                  ram_wen,
  output logic [ADDR-1:0]       ram_wadd,
  output logic [WIDTH-1:0]      ram_wdat,
  output logic [3:0]            au_opcode,
  output logic                  au_start,
  output logic                  au_carry,
  input  logic                  au_vld,
  output logic [NENG-1:0]       eng_auvld
);
  localparam int              DEPTH  = 1 << QLOG;
  localparam logic [MWID:0]   NENG_W = (MWID+1)'(NENG);
  // Watchdog counts completed RUN cycles, so the (2^TWID-1)th RUN cycle sees all-ones minus one.
  localparam logic [TWID-1:0] TMO_AT = {{(TWID-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIN} state_t;
  typedef enum logic [1:0] {ST_IDLE, ST_CAL, ST_DONE, ST_ERR} status_t;

  state_t  state, state_nxt;
  status_t status, verdict;

  logic [MWID+WIDTH-1:0] fifo_mem [DEPTH];
  logic [QLOG-1:0]       wr_ptr, rd_ptr;
  logic [QLOG:0]         fifo_cnt;
  logic                  push, pop, empty, full, mode_ok;
  logic [MWID-1:0]       head_mode;
  logic [WIDTH-1:0]      head_dat;

  assign empty   = fifo_cnt == '0;
  assign full    = fifo_cnt == (QLOG+1)'(DEPTH);
  assign cmd_rdy = ~full;
  assign push    = cmd_vld & ~full;
  assign pop     = (state == S_IDLE) & ~empty;
  assign {head_mode, head_dat} = fifo_mem[rd_ptr];
  assign mode_ok = {1'b0, head_mode} < NENG_W;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_mode, cmd_dat};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + QLOG'(1);
      if (pop)  rd_ptr <= rd_ptr + QLOG'(1);
      fifo_cnt <= fifo_cnt + (QLOG+1)'(push) - (QLOG+1)'(pop);
    end
  end

  logic [MWID-1:0]  sel;
  logic [NENG-1:0]  sel_oh;
  logic [ADDR-1:0]  s_radd, s_wadd;
  logic [WIDTH-1:0] s_wdat, dat_q, rslt_q;
  logic [3:0]       s_auop;
  logic             s_wen, s_austart, s_carry, s_vld, s_zchk;
  logic [TWID-1:0]  wdog;
  logic             tmo, bad_q, au_start_q;

  always_comb begin
    sel_oh    = '0;
    s_radd    = '0;
    s_wadd    = '0;
    s_wdat    = '0;
    s_auop    = '0;
    s_wen     = 1'b0;
    s_austart = 1'b0;
    s_carry   = 1'b0;
    s_vld     = 1'b0;
    s_zchk    = 1'b0;
    for (int unsigned i = 0; i < NENG; i++) begin
      if (sel == MWID'(i)) begin
        sel_oh[i] = 1'b1;
        s_radd    = eng_radd[i*ADDR +: ADDR];
        s_wadd    = eng_wadd[i*ADDR +: ADDR];
        s_wdat    = eng_wdat[i*WIDTH +: WIDTH];
        s_auop    = eng_auop[i*4 +: 4];
        s_wen     = eng_wen[i];
        s_austart = eng_austart[i];
        s_carry   = eng_carry[i];
        s_vld     = eng_vld[i];
        s_zchk    = ZCHK[i];
      end
    end
  end

  assign tmo = wdog == TMO_AT;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop & mode_ok) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (s_vld | tmo) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '0;
      dat_q      <= '0;
      rslt_q     <= '0;
      wdog       <= '0;
      verdict    <= ST_IDLE;
      bad_q      <= 1'b0;
      au_start_q <= 1'b0;
    end else begin
      bad_q      <= pop & ~mode_ok;
      // Only carry the AU start forward while the engine keeps the mux next cycle.
      au_start_q <= (state == S_RUN) & (state_nxt == S_RUN) & s_austart;
      if (pop & mode_ok) begin
        sel   <= head_mode;
        dat_q <= head_dat;
      end
      if (state == S_LOAD)     wdog <= '0;
      else if (state == S_RUN) wdog <= wdog + TWID'(1);
      if (state == S_RUN) begin
        if (s_vld) begin
          rslt_q  <= s_wdat;
          verdict <= (s_zchk && s_wdat == '0) ? ST_ERR : ST_DONE;
        end else if (tmo) begin
          verdict <= ST_ERR;
        end
      end
    end
  end

  always_comb begin
    eng_start = '0;
    eng_abort = '0;
    eng_auvld = '0;
    ram_radd  = '0;
    ram_wen   = 1'b0;
    ram_wadd  = '0;
    ram_wdat  = '0;
    au_opcode = '0;
    au_carry  = 1'b0;
    status    = bad_q ? ST_ERR : ST_IDLE;
    case (state)
      S_LOAD: begin
        ram_wen   = 1'b1;
        ram_wadd  = ADDR'(CMD_ADD);
        ram_wdat  = dat_q;
        eng_start = sel_oh;
        status    = ST_CAL;
      end
      S_RUN: begin
        ram_radd  = s_radd;
        ram_wen   = s_wen;
        ram_wadd  = s_wadd;
        ram_wdat  = s_wdat;
        au_opcode = s_auop;
        au_carry  = s_carry;
        eng_auvld = sel_oh & {NENG{au_vld}};
        if (tmo & ~s_vld) eng_abort = sel_oh;
        status    = ST_CAL;
      end
      S_FIN:   status = verdict;
      default: ;
    endcase
  end

  assign auc_status = status;
  assign auc_rslt   = rslt_q;
  assign au_start   = au_start_q;
  assign auc_busy   = (state != S_IDLE) | ~empty;

endmodule

// File: tb/tb_auc_sched.sv
// Randomized bench for auc_sched: engine responders with planned latencies and a
// transaction-level scoreboard of dispatch order, verdicts and mux routing.
module tb_auc_sched;
  localparam int W  = 32;
  localparam int NE = 6;
  localparam int AW = 5;
  localparam int MW = 3;
  localparam logic [NE-1:0] ZC = 6'b001100;

  logic clk, rst;
  logic cmd_vld, cmd_rdy;
  logic [MW-1:0] cmd_mode;
  logic [W-1:0] cmd_dat, auc_rslt;
  logic [1:0] auc_status;
  logic auc_busy;
  logic [NE-1:0] eng_start, eng_abort, eng_vld, eng_wen, eng_austart, eng_carry, eng_auvld;
  logic [NE*AW-1:0] eng_radd, eng_wadd;
  logic [NE*W-1:0] eng_wdat;
  logic [NE*4-1:0] eng_auop;
  logic [AW-1:0] ram_radd, ram_wadd;
  logic ram_wen, au_start, au_carry, au_vld;
  logic [W-1:0] ram_wdat;
  logic [3:0] au_opcode;

  auc_sched #(.WIDTH(W), .TWID(4)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_mode(cmd_mode),
    .cmd_dat(cmd_dat), .auc_rslt(auc_rslt), .auc_status(auc_status), .auc_busy(auc_busy),
    .eng_start(eng_start), .eng_abort(eng_abort), .eng_vld(eng_vld), .eng_radd(eng_radd),
    .eng_wen(eng_wen), .eng_wadd(eng_wadd), .eng_wdat(eng_wdat), .eng_auop(eng_auop),
    .eng_austart(eng_austart), .eng_carry(eng_carry), .ram_radd(ram_radd), .ram_wen(ram_wen),
    .ram_wadd(ram_wadd), .ram_wdat(ram_wdat), .au_opcode(au_opcode), .au_start(au_start),
    .au_carry(au_carry), .au_vld(au_vld), .eng_auvld(eng_auvld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int mode; logic [W-1:0] dat; } cmd_t;
  typedef struct { bit resp; int lat; logic [W-1:0] val; } plan_t;

  cmd_t  expq[$];
  plan_t planq[$];
  int total = 0, bad = 0;

  bit act = 0, prev_as = 0;
  int act_e = 0, cnt = 0, last_ver = 0, noise_e = 0;
  plan_t pl;
  logic [W-1:0] exp_rslt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Engines, noise and scoreboard: drive at negedge, observe 1 time unit later.
  always @(negedge clk) begin
    cmd_t f;
    for (int e = 0; e < NE; e++) begin
      eng_radd[e*AW +: AW] = AW'($urandom);
      eng_wadd[e*AW +: AW] = AW'($urandom);
      eng_wdat[e*W +: W]   = $urandom;
      eng_auop[e*4 +: 4]   = 4'($urandom);
    end
    eng_wen = NE'($urandom); eng_austart = NE'($urandom); eng_carry = NE'($urandom);
    au_vld = 1'($urandom); eng_vld = '0;
    if (act) begin
      cnt++;
      if (pl.resp && cnt == pl.lat) begin
        eng_vld[act_e] = 1'b1;
        eng_wdat[act_e*W +: W] = pl.val;
      end
      if ($urandom_range(0, 2) == 0) begin
        noise_e = (act_e + 1 + int'($urandom_range(0, NE-2))) % NE;
        eng_vld[noise_e] = 1'b1;
      end
    end
    #1;
    if (rst) begin
      act = 0; expq.delete(); exp_rslt = '0;
    end else if (!act) begin
      if (eng_start != '0) begin
        if (expq.size() == 0) chk("spurious_start", eng_start, 0);
        else begin
          f = expq.pop_front();
          chk("start_onehot", eng_start, (f.mode < NE) ? (64'd1 << f.mode) : 64'd0);
          chk("load_wen", ram_wen, 1);
          chk("load_wadd", ram_wadd, 11);
          chk("load_wdat", ram_wdat, f.dat);
          chk("load_status", auc_status, 1);
          chk("load_austart", au_start, 0);
          if (f.mode < NE) begin
            act = 1; act_e = f.mode; cnt = 0;
            if (planq.size() > 0) pl = planq.pop_front();
            else begin
              pl.resp = ($urandom_range(0, 9) != 0);
              pl.lat  = $urandom_range(1, 15);
              pl.val  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            end
          end
        end
      end else if (auc_status == 2'd3) begin
        if (expq.size() == 0) chk("spurious_error", 1, 0);
        else begin
          f = expq.pop_front();
          chk("illegal_mode", f.mode >= NE, 1);
          chk("illegal_rslt", auc_rslt, exp_rslt);
          last_ver = 3;
        end
      end else begin
        chk("idle_status", auc_status, 0);
        chk("idle_outs", {ram_wen, au_start, |eng_auvld, |ram_radd, |eng_abort}, 0);
      end
    end else if (auc_status == 2'd1) begin
      chk("run_radd", ram_radd, eng_radd[act_e*AW +: AW]);
      chk("run_wadd", ram_wadd, eng_wadd[act_e*AW +: AW]);
      chk("run_wdat", ram_wdat, eng_wdat[act_e*W +: W]);
      chk("run_wen", ram_wen, eng_wen[act_e]);
      chk("run_auop", au_opcode, eng_auop[act_e*4 +: 4]);
      chk("run_carry", au_carry, eng_carry[act_e]);
      chk("run_auvld", eng_auvld, au_vld ? (64'd1 << act_e) : 64'd0);
      chk("run_start", eng_start, 0);
      if (cnt >= 2) chk("run_austart", au_start, prev_as);
      chk("run_abort", eng_abort,
          (cnt == 15 && !(pl.resp && pl.lat == 15)) ? (64'd1 << act_e) : 64'd0);
      if (cnt > 16) begin chk("run_overrun", cnt, 16); act = 0; end
    end else if (auc_status >= 2'd2) begin
      if (pl.resp) exp_rslt = pl.val;
      chk("verdict", auc_status, (pl.resp && !(ZC[act_e] && pl.val == '0)) ? 2 : 3);
      chk("fin_cycle", cnt, pl.resp ? pl.lat + 1 : 16);
      chk("fin_rslt", auc_rslt, exp_rslt);
      chk("fin_outs", {au_start, ram_wen, |eng_auvld, |eng_abort}, 0);
      last_ver = auc_status;
      act = 0;
    end else begin
      chk("run_status", auc_status, 1);
      act = 0;
    end
    prev_as = act ? eng_austart[act_e] : 1'b0;
  end

  task automatic push(input int mode, input logic [W-1:0] dat);
    int n;
    cmd_t c;
    @(negedge clk);
    cmd_vld = 1'b1; cmd_mode = MW'(mode); cmd_dat = dat;
    #1; n = 0;
    while (!cmd_rdy && n < 100) begin @(negedge clk); #1; n++; end
    if (!cmd_rdy) chk("push_stall", 0, 1);
    else begin c.mode = mode; c.dat = dat; expq.push_back(c); end
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); #3; n++; end
    while ((auc_busy || act || expq.size() != 0) && n < 400);
    if (n >= 400) chk("idle_timeout", 0, 1);
  endtask

  task automatic add_plan(input bit resp, input int lat, input logic [W-1:0] val);
    plan_t p;
    p.resp = resp; p.lat = lat; p.val = val;
    planq.push_back(p);
  endtask

  initial begin
    cmd_t c;
    int n;
    rst = 1'b1; cmd_vld = 1'b0; cmd_mode = '0; cmd_dat = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outs", {|auc_rslt, auc_status, auc_busy, |eng_start, |eng_abort, ram_wen,
                       |ram_radd, |ram_wadd, |ram_wdat, |au_opcode, au_start, au_carry,
                       |eng_auvld}, 0);
    chk("reset_rdy", cmd_rdy, 1);
    rst = 1'b0;

    // Dispatch latency and LOAD contents.
    add_plan(1, 3, 32'h1234);
    push(4, 32'h5A);
    #2 chk("lat_t1_start", eng_start, 0);
    @(negedge clk); #2;
    chk("lat_t2_start", eng_start, 6'b010000);
    chk("lat_t2_wadd", ram_wadd, 11);
    chk("lat_t2_wdat", ram_wdat, 32'h5A);
    wait_idle();
    chk("m4_rslt", auc_rslt, 32'h1234);
    chk("m4_verdict", last_ver, 2);

    // Illegal mode leaves the result untouched.
    push(7, 32'hDEAD);
    wait_idle();
    chk("m7_verdict", last_ver, 3);
    chk("m7_rslt", auc_rslt, 32'h1234);

    // Zero result: ERROR only where the zero-check mask is set.
    add_plan(1, 2, '0);
    push(2, 32'h11);
    wait_idle();
    chk("m2_zero_verdict", last_ver, 3);
    add_plan(1, 4, '0);
    push(5, 32'h22);
    wait_idle();
    chk("m5_zero_verdict", last_ver, 2);

    // Silent engine times out, next command still dispatches.
    add_plan(0, 1, '0);
    add_plan(1, 2, 32'hBEEF);
    push(1, 32'h33);
    push(3, 32'h44);
    wait_idle();
    chk("after_tmo_rslt", auc_rslt, 32'hBEEF);

    // Done on the timeout cycle itself.
    add_plan(1, 15, 32'h77);
    push(4, 32'h55);
    wait_idle();
    chk("vld_at_tmo_verdict", last_ver, 2);
    chk("vld_at_tmo_rslt", auc_rslt, 32'h77);

    // Fill the FIFO while engine 0 is stalled.
    add_plan(1, 14, 32'hA0);
    push(0, 32'h66);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmd_vld = 1'b1; cmd_mode = MW'((k * 2 + 1) % NE); cmd_dat = W'($urandom);
      #1;
      chk("fill_rdy", cmd_rdy, (k < 4) ? 1 : 0);
      if (cmd_rdy) begin c.mode = (k * 2 + 1) % NE; c.dat = cmd_dat; expq.push_back(c); end
    end
    @(negedge clk);
    cmd_vld = 1'b0;
    wait_idle();

    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push($urandom_range(0, 7), W'($urandom));
    end
    wait_idle();

    // Reset in the middle of RUN drops everything without an abort.
    add_plan(0, 1, '0);
    push(0, 32'h99);
    push(2, 32'h98);
    push(3, 32'h97);
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!(act && cnt >= 3) && n < 40);
    chk("reach_run", act, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #2;
    chk("midrun_reset_outs", {|auc_rslt, auc_status, auc_busy, |eng_start, |eng_abort, ram_wen,
                              |ram_radd, au_start, |eng_auvld}, 0);
    chk("midrun_reset_rdy", cmd_rdy, 1);
    rst = 1'b0;
    planq.delete();
    repeat (6) begin
      @(negedge clk); #2;
      chk("post_reset_quiet", {auc_busy, |eng_start, |eng_abort}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
